// File: rtl/lcd_char_pacer.sv
// Character FIFO and strobe pacer feeding the LCD character-writer stage.
// Bytes are queued in bursts and released one at a time with a one-cycle
// ds_out strobe, spaced so the LCD stage finishes init and each write or
// backspace sequence before the next byte arrives.
module lcd_char_pacer #(
    parameter int unsigned DEPTH     = 16,
    parameter int unsigned AW        = 4,
    parameter int unsigned INIT_WAIT = 3000000,
    parameter int unsigned CHAR_GAP  = 20000,
    parameter int unsigned BS_GAP    = 40000,
    parameter int unsigned CW        = 22
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic [7:0]    ascii_in,
    input  logic          wr_stb,
    input  logic          clr,
    output logic [7:0]    ascii_out,
    output logic          ds_out,
    output logic          empty,
    output logic          full,
    output logic          overflow,
    output logic [AW:0]   count
);

    typedef enum logic [1:0] {StInit, StIdle, StIssue, StGap} state_e;

    // The FSM leaves INIT/GAP on the edge where the counter reaches zero, so
    // a gap load of N-2 plus one IDLE and one ISSUE cycle spaces strobes N apart.
    localparam logic [CW-1:0] InitLoad = CW'(INIT_WAIT - 1);
    localparam logic [CW-1:0] CharLoad = CW'(CHAR_GAP - 2);
    localparam logic [CW-1:0] BsLoad   = CW'(BS_GAP - 2);
    localparam logic [AW:0]   DepthCnt = (AW + 1)'(DEPTH);

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [7:0]      ascii_q, ascii_d;
    logic            ds_q, ds_d;
    logic            pop;
    logic [AW-1:0]   wptr_q, rptr_q;
    logic [AW:0]     count_q;
    logic            overflow_q;
    logic            push_ok;
    logic [7:0]      mem [DEPTH];

    // Push is accepted against occupancy before any same-cycle pop; clr wins.
    assign push_ok = wr_stb && !clr && (count_q < DepthCnt);

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StInit;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            StInit:  if (cnt_q <= CW'(1)) state_d = StIdle;
            StIdle:  if (count_q != '0) state_d = StIssue;
            // A clr during the IDLE cycle can leave nothing to issue.
            StIssue: state_d = (count_q != '0) ? StGap : StIdle;
            StGap:   if (cnt_q <= CW'(1)) state_d = StIdle;
            default: state_d = StInit;
        endcase
    end

    // Output and counter next-state logic.
    always_comb begin
        ascii_d = ascii_q;
        ds_d    = 1'b0;
        pop     = 1'b0;
        cnt_d   = cnt_q;
        case (state_q)
            StInit, StGap: begin
                if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
            end
            StIssue: begin
                if (count_q != '0) begin
                    pop     = 1'b1;
                    ds_d    = 1'b1;
                    ascii_d = mem[rptr_q];
                    cnt_d   = (mem[rptr_q] == 8'h08) ? BsLoad : CharLoad;
                end
            end
            default: ;
        endcase
    end

    // Registered outputs and pacing counter.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ascii_q <= 8'h00;
            ds_q    <= 1'b0;
            cnt_q   <= InitLoad;
        end else begin
            ascii_q <= ascii_d;
            ds_q    <= ds_d;
            cnt_q   <= cnt_d;
        end
    end

    // FIFO pointers, occupancy and sticky overflow.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else if (clr) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (push_ok) wptr_q <= wptr_q + 1'b1;
            if (pop)     rptr_q <= rptr_q + 1'b1;
            if (push_ok && !pop) begin
                count_q <= count_q + 1'b1;
            end else if (pop && !push_ok) begin
                count_q <= count_q - 1'b1;
            end
            if (wr_stb && !push_ok) overflow_q <= 1'b1;
        end
    end

    // FIFO storage.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wptr_q] <= ascii_in;
    end

    assign ascii_out = ascii_q;
    assign ds_out    = ds_q;
    assign empty     = (count_q == '0);
    assign full      = (count_q == DepthCnt);
    assign overflow  = overflow_q;
    assign count     = count_q;

endmodule
